// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the scoreboarded register file: read ports, writeback and decode-claim
// signals, plus scoreboard status.
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  we;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  claim_en;
    logic [ADDR_W-1:0]     claim_addr;
    logic [ADDR_W:0]       busy_cnt;
    logic                  full_busy;

    modport master (
        output rd_addr, we, wr_addr, wr_data, claim_en, claim_addr,
        input  rd_data, rd_busy, busy_cnt, full_busy
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, claim_en, claim_addr,
        output rd_data, rd_busy, busy_cnt, full_busy
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with same-cycle write forwarding and a per-register busy
// scoreboard: decode claims a destination, writeback writes it and releases the claim.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    regfile_mp_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH - ZERO_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   busy_cnt_r;
    logic              full;
    logic              wr_ok;
    logic              claim_ok;
    logic [DATA_W-1:0] rdat [NRD];
    logic [NRD-1:0]    rbsy;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + (ADDR_W+1)'(v[i]);
        end
        return n;
    endfunction

    assign full     = (busy_cnt_r == FULL_CNT);
    assign wr_ok    = bus.we && !is_zero_reg(bus.wr_addr);
    // A claim while every claimable register is busy is dropped entirely.
    assign claim_ok = bus.claim_en && !full && !is_zero_reg(bus.claim_addr);

    // Clear first, then set, so a same-cycle write+claim leaves the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[bus.wr_addr] = 1'b0;
        end
        if (claim_ok) begin
            busy_nxt[bus.claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_cnt_r <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_cnt_r <= popcount(busy_nxt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Forwarding is suppressed during reset so outputs read as zero while rst is high.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              fwd;
        logic              reclaim;

        assign addr    = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign fwd     = bus.we && (bus.wr_addr == addr);
        assign reclaim = claim_ok && (bus.claim_addr == bus.wr_addr);

        always_comb begin
            rdat[k] = '0;
            rbsy[k] = 1'b0;
            if (!rst && !is_zero_reg(addr)) begin
                rdat[k] = fwd ? bus.wr_data : mem[addr];
                rbsy[k] = busy[addr] && !(fwd && !reclaim);
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            bus.rd_data[k*DATA_W +: DATA_W] = rdat[k];
        end
    end

    assign bus.rd_busy   = rbsy;
    assign bus.busy_cnt  = busy_cnt_r;
    assign bus.full_busy = full && !rst;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a 32x32 instance for forwarding/scoreboard behaviour and
// a 4-entry instance for the full-scoreboard boundary.
module tb_regfile_mp_sb;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) m_if ();
    regfile_mp_sb_if #(.DATA_W(8),  .ADDR_W(2), .NRD(2)) s_if ();

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    regfile_mp_sb #(.DATA_W(8), .ADDR_W(2), .NRD(2), .ZERO_REG(1)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        m_if.rd_addr = '0; m_if.we = 1'b0; m_if.wr_addr = '0; m_if.wr_data = '0;
        m_if.claim_en = 1'b0; m_if.claim_addr = '0;
        s_if.rd_addr = '0; s_if.we = 1'b0; s_if.wr_addr = '0; s_if.wr_data = '0;
        s_if.claim_en = 1'b0; s_if.claim_addr = '0;
        #2;
        chk("reset_busy_cnt", m_if.busy_cnt, 0);
        chk("reset_full", m_if.full_busy, 0);
        chk("reset_rd_busy", m_if.rd_busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Same-cycle forwarding, then readback from storage
        tick();
        m_if.we = 1'b1; m_if.wr_addr = 5'd5; m_if.wr_data = 32'hDEADBEEF;
        m_if.rd_addr = {5'd0, 5'd5};
        #1;
        chk("fwd_rd0", m_if.rd_data[31:0], 32'hDEADBEEF);
        chk("fwd_rd1_r0", m_if.rd_data[63:32], 0);
        tick();
        m_if.we = 1'b0;
        #1;
        chk("stored_rd0", m_if.rd_data[31:0], 32'hDEADBEEF);

        // Register 0 ignores writes and claims
        m_if.we = 1'b1; m_if.wr_addr = 5'd0; m_if.wr_data = 32'h1234;
        m_if.claim_en = 1'b1; m_if.claim_addr = 5'd0;
        m_if.rd_addr = {5'd0, 5'd0};
        #1;
        chk("r0_fwd", m_if.rd_data[31:0], 0);
        tick();
        m_if.we = 1'b0; m_if.claim_en = 1'b0;
        #1;
        chk("r0_read", m_if.rd_data[31:0], 0);
        chk("r0_busy_cnt", m_if.busy_cnt, 0);

        // Claim r7 and r9, then release r7
        m_if.claim_en = 1'b1; m_if.claim_addr = 5'd7;
        tick();
        chk("claim1_cnt", m_if.busy_cnt, 1);
        m_if.claim_addr = 5'd9;
        tick();
        m_if.claim_en = 1'b0;
        m_if.rd_addr = {5'd9, 5'd7};
        #1;
        chk("claim2_cnt", m_if.busy_cnt, 2);
        chk("claim2_rd_busy", m_if.rd_busy, 2'b11);
        m_if.we = 1'b1; m_if.wr_addr = 5'd7; m_if.wr_data = 32'h0000_0077;
        #1;
        chk("wb_rd_busy_same", m_if.rd_busy, 2'b10);
        chk("wb_fwd_r7", m_if.rd_data[31:0], 32'h77);
        tick();
        m_if.we = 1'b0;
        #1;
        chk("wb_cnt_next", m_if.busy_cnt, 1);
        chk("wb_rd_busy_next", m_if.rd_busy, 2'b10);

        // Simultaneous write and claim of busy r3
        m_if.claim_en = 1'b1; m_if.claim_addr = 5'd3;
        tick();
        m_if.claim_en = 1'b0;
        #1;
        chk("claim_r3_cnt", m_if.busy_cnt, 2);
        m_if.we = 1'b1; m_if.wr_addr = 5'd3; m_if.wr_data = 32'h0000_AAAA;
        m_if.claim_en = 1'b1; m_if.claim_addr = 5'd3;
        m_if.rd_addr = {5'd9, 5'd3};
        #1;
        chk("wc_rd_busy_same", m_if.rd_busy, 2'b11);
        chk("wc_fwd", m_if.rd_data[31:0], 32'hAAAA);
        tick();
        m_if.we = 1'b0; m_if.claim_en = 1'b0;
        #1;
        chk("wc_cnt", m_if.busy_cnt, 2);
        chk("wc_rd_busy", m_if.rd_busy, 2'b11);
        chk("wc_data", m_if.rd_data[31:0], 32'hAAAA);

        // Write to non-busy r12, re-claim busy r9: count unchanged
        m_if.we = 1'b1; m_if.wr_addr = 5'd12; m_if.wr_data = 32'h0C0C_0C0C;
        m_if.claim_en = 1'b1; m_if.claim_addr = 5'd9;
        tick();
        m_if.we = 1'b0; m_if.claim_en = 1'b0;
        m_if.rd_addr = {5'd9, 5'd12};
        #1;
        chk("nonbusy_wr_cnt", m_if.busy_cnt, 2);
        chk("nonbusy_wr_data", m_if.rd_data[31:0], 32'h0C0C_0C0C);
        chk("reclaim_busy", m_if.rd_busy, 2'b10);

        // Asynchronous reset mid-cycle with a write pending
        m_if.rd_addr = {5'd9, 5'd5};
        m_if.we = 1'b1; m_if.wr_addr = 5'd6; m_if.wr_data = 32'h5555_5555;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_rd0", m_if.rd_data[31:0], 0);
        chk("arst_rd1", m_if.rd_data[63:32], 0);
        chk("arst_rd_busy", m_if.rd_busy, 0);
        chk("arst_cnt", m_if.busy_cnt, 0);
        tick();
        m_if.we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_if.rd_addr = {5'd5, 5'd6};
        #1;
        chk("post_rst_r6", m_if.rd_data[31:0], 0);
        chk("post_rst_r5", m_if.rd_data[63:32], 0);
        m_if.claim_en = 1'b1; m_if.claim_addr = 5'd4;
        tick();
        m_if.claim_en = 1'b0;
        #1;
        chk("post_rst_claim_cnt", m_if.busy_cnt, 1);

        // Small instance: fill the scoreboard
        s_if.claim_en = 1'b1; s_if.claim_addr = 2'd1;
        tick();
        s_if.claim_addr = 2'd2;
        tick();
        #1;
        chk("s_cnt2", s_if.busy_cnt, 2);
        chk("s_not_full", s_if.full_busy, 0);
        s_if.claim_addr = 2'd3;
        tick();
        s_if.claim_en = 1'b0;
        #1;
        chk("s_full", s_if.full_busy, 1);
        chk("s_cnt3", s_if.busy_cnt, 3);
        s_if.claim_en = 1'b1; s_if.claim_addr = 2'd1;
        tick();
        s_if.claim_en = 1'b0;
        #1;
        chk("s_full_claim_cnt", s_if.busy_cnt, 3);
        s_if.we = 1'b1; s_if.wr_addr = 2'd2; s_if.wr_data = 8'h5A;
        tick();
        s_if.we = 1'b0;
        s_if.rd_addr = {2'd1, 2'd2};
        #1;
        chk("s_release_full", s_if.full_busy, 0);
        chk("s_release_cnt", s_if.busy_cnt, 2);
        chk("s_release_busy", s_if.rd_busy, 2'b10);
        chk("s_release_data", s_if.rd_data[7:0], 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
